tf_src_rr_sched: RTL and testbench

//  Round-robin packet scheduler that shares one 512-to-8 transmit path between NUM_SRC packet sources.
//  - Each source presents first-word-fall-through (FWFT) data and metadata FIFOs.
//  - Packets are moved whole, never interleaved: 520-bit data words plus one 112-bit metadata word per packet.
//  - Sits directly upstream of the 512-to-8 serializer; throttled by the serializer's almost-full.

---
 rtl/tf_src_rr_sched_if.sv | 31 +++
 rtl/tf_src_rr_sched.sv | 141 ++++++++++++++
 tb/tb_tf_src_rr_sched.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tf_src_rr_sched_if.sv
// tf_src_rr_sched_if: source-FIFO and serializer handshake bundle for tf_src_rr_sched.
// master = scheduler side, slave = sources/serializer side.
interface tf_src_rr_sched_if #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 520,
    parameter int MW      = 112
);
    logic [NUM_SRC*DW-1:0] src_data;
    logic [NUM_SRC-1:0]    src_data_rd;
    logic [NUM_SRC*MW-1:0] src_meta;
    logic [NUM_SRC-1:0]    src_meta_empty;
    logic [NUM_SRC-1:0]    src_meta_rd;
    logic [DW-1:0]         out_data;
    logic                  out_data_wr;
    logic [MW-1:0]         out_meta;
    logic                  out_meta_wr;
    logic                  out_alf;
    logic [2:0]            grant_id;
    logic [15:0]           zero_len_cnt;

    modport master (
        input  src_data, src_meta, src_meta_empty, out_alf,
        output src_data_rd, src_meta_rd, out_data, out_data_wr, out_meta, out_meta_wr,
               grant_id, zero_len_cnt
    );
    modport slave (
        output src_data, src_meta, src_meta_empty, out_alf,
        input  src_data_rd, src_meta_rd, out_data, out_data_wr, out_meta, out_meta_wr,
               grant_id, zero_len_cnt
    );
endinterface

// File: rtl/tf_src_rr_sched.sv
// tf_src_rr_sched: whole-packet round-robin scheduler feeding the 512-to-8 serializer.
// Define TF_SCHED_STRICT_PRIO_EN to make source 0 strict priority over the round robin.
module tf_src_rr_sched #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 520,
    parameter int MW      = 112
) (
    input  logic              clk,
    input  logic              rst_n,
    tf_src_rr_sched_if.master bus
);
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [NUM_SRC-1:0] ONE = 1;

    state_t             state_q, state_d;
    logic [2:0]         rr_q, rr_d, grant_q, grant_d, g;
    logic [5:0]         words_q, words_d;
    logic [15:0]        zcnt_q, zcnt_d;
    logic [DW-1:0]      odata_q, odata_d;
    logic               odata_wr_q, odata_wr_d;
    logic [MW-1:0]      ometa_q, ometa_d;
    logic               ometa_wr_q, ometa_wr_d;
    logic [NUM_SRC-1:0] ne, meta_rd, data_rd;
    logic [7:0]         ne8;
    logic [DW-1:0]      data_a [8];
    logic [MW-1:0]      meta_a [8];
    logic               found;
    logic [3:0]         idx;
    logic [10:0]        len;

    assign ne  = ~bus.src_meta_empty;
    assign ne8 = 8'(ne);

    // Pad the per-source views to 8 so a 3-bit grant can index them directly
    for (genvar i = 0; i < 8; i++) begin : g_src
        if (i < NUM_SRC) begin : g_on
            assign data_a[i] = bus.src_data[i*DW +: DW];
            assign meta_a[i] = bus.src_meta[i*MW +: MW];
        end else begin : g_off
            assign data_a[i] = '0;
            assign meta_a[i] = '0;
        end
    end

    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = {1'b0, rr_q} + 4'(k);
            idx = (idx >= 4'(NUM_SRC)) ? idx - 4'(NUM_SRC) : idx;
`ifdef TF_SCHED_STRICT_PRIO_EN
            if (!found && idx != 4'd0 && ne8[idx[2:0]]) begin
`else
            if (!found && ne8[idx[2:0]]) begin
`endif
                found = 1'b1;
                g     = idx[2:0];
            end
        end
`ifdef TF_SCHED_STRICT_PRIO_EN
        if (ne8[0]) begin
            found = 1'b1;
            g     = 3'd0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        words_d    = words_q;
        zcnt_d     = zcnt_q;
        odata_d    = odata_q;
        odata_wr_d = 1'b0;
        ometa_d    = ometa_q;
        ometa_wr_d = 1'b0;
        meta_rd    = '0;
        data_rd    = '0;
        len        = meta_a[g][106:96];
        if (state_q == IDLE) begin
            if (!bus.out_alf && found) begin
                meta_rd = ONE << g;
                grant_d = g;
`ifdef TF_SCHED_STRICT_PRIO_EN
                rr_d    = (g == 3'd0) ? rr_q : g;
`else
                rr_d    = g;
`endif
                words_d = 6'((12'(len) + 12'd63) >> 6);
                if (len != 11'd0) begin
                    ometa_d    = meta_a[g];
                    ometa_wr_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    zcnt_d = zcnt_q + {15'd0, zcnt_q != 16'hFFFF};
                end
            end
        end else if (!bus.out_alf) begin
            data_rd    = ONE << grant_q;
            odata_d    = data_a[grant_q];
            odata_wr_d = 1'b1;
            words_d    = words_q - 6'd1;
            state_d    = (words_q == 6'd1) ? IDLE : SEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 3'(NUM_SRC - 1);
            grant_q    <= '0;
            words_q    <= '0;
            zcnt_q     <= '0;
            odata_q    <= '0;
            odata_wr_q <= 1'b0;
            ometa_q    <= '0;
            ometa_wr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            words_q    <= words_d;
            zcnt_q     <= zcnt_d;
            odata_q    <= odata_d;
            odata_wr_q <= odata_wr_d;
            ometa_q    <= ometa_d;
            ometa_wr_q <= ometa_wr_d;
        end
    end

    assign bus.src_meta_rd  = meta_rd;
    assign bus.src_data_rd  = data_rd;
    assign bus.out_data     = odata_q;
    assign bus.out_data_wr  = odata_wr_q;
    assign bus.out_meta     = ometa_q;
    assign bus.out_meta_wr  = ometa_wr_q;
    assign bus.grant_id     = grant_q;
    assign bus.zero_len_cnt = zcnt_q;
endmodule

// File: tb/tb_tf_src_rr_sched.sv
// tb_tf_src_rr_sched: FWFT source models plus a packet-level round-robin model;
// the observed meta/data write stream is compared against the model's stream.
module tb_tf_src_rr_sched;
    localparam int N  = 4;
    localparam int DW = 520;
    localparam int MW = 112;

    typedef struct packed {
        logic          m;
        logic [2:0]    g;
        logic [DW-1:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0, miscompares = 0, cyc = 0, pop_err = 0;
    int m_rr = N - 1, m_zc = 0;
    logic [DW-1:0] dq [N][$];
    logic [MW-1:0] mq [N][$];
    logic [DW-1:0] pd [N][$];
    logic [MW-1:0] pm [N][$];
    ev_t obs[$], exp_q[$];
    int meta_cyc[$];
    logic [N-1:0] rd_m = '0, rd_d = '0;
    logic [DW-1:0] aa;

    tf_src_rr_sched_if #(.NUM_SRC(N), .DW(DW), .MW(MW)) bus ();
    tf_src_rr_sched #(.NUM_SRC(N), .DW(DW), .MW(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic set_heads();
        for (int i = 0; i < N; i++) begin
            bus.src_data[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0] : '0;
            bus.src_meta[i*MW +: MW] = (mq[i].size() > 0) ? mq[i][0] : '0;
            bus.src_meta_empty[i]    = (mq[i].size() == 0);
        end
    endtask

    // Pop strobes are stable from the falling edge until the next rising edge
    always @(negedge clk) begin
        rd_m = bus.src_meta_rd;
        rd_d = bus.src_data_rd;
        if (rst_n) begin
            cyc++;
            if (bus.out_meta_wr) begin
                obs.push_back({1'b1, bus.grant_id, DW'(bus.out_meta)});
                meta_cyc.push_back(cyc);
            end
            if (bus.out_data_wr) obs.push_back({1'b0, bus.grant_id, bus.out_data});
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_m[i]) begin
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                else pop_err++;
            end
            if (rd_d[i]) begin
                if (dq[i].size() > 0) void'(dq[i].pop_front());
                else pop_err++;
            end
        end
        set_heads();
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < 17; i++) w = {w[DW-33:0], 32'($urandom)};
        return w;
    endfunction

    task automatic add_pkt(input int s, input int len, input bit fixed, input logic [DW-1:0] fill);
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        m = MW'({$urandom, $urandom, $urandom, $urandom});
        m[106:96] = 11'(len);
        for (int w = 0; w < (len + 63) / 64; w++) begin
            d = fixed ? fill : rnd_word();
            dq[s].push_back(d);
            pd[s].push_back(d);
        end
        mq[s].push_back(m);
        pm[s].push_back(m);
        set_heads();
    endtask

    // Packet-level arbitration over everything queued: cyclic search after the last winner
    task automatic run_model();
        int g, j, len;
        logic [MW-1:0] m;
        while (1) begin
            g = -1;
`ifdef TF_SCHED_STRICT_PRIO_EN
            if (pm[0].size() > 0) g = 0;
`endif
            for (int k = 1; k <= N && g < 0; k++) begin
                j = (m_rr + k) % N;
`ifdef TF_SCHED_STRICT_PRIO_EN
                if (j != 0 && pm[j].size() > 0) g = j;
`else
                if (pm[j].size() > 0) g = j;
`endif
            end
            if (g < 0) break;
`ifdef TF_SCHED_STRICT_PRIO_EN
            if (g != 0) m_rr = g;
`else
            m_rr = g;
`endif
            m = pm[g].pop_front();
            len = int'(m[106:96]);
            if (len == 0) m_zc = (m_zc < 65535) ? m_zc + 1 : m_zc;
            else begin
                exp_q.push_back({1'b1, 3'(g), DW'(m)});
                for (int w = 0; w < (len + 63) / 64; w++) exp_q.push_back({1'b0, 3'(g), pd[g].pop_front()});
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        obs.delete();
        exp_q.delete();
        meta_cyc.delete();
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            mq[i].delete();
            pd[i].delete();
            pm[i].delete();
        end
        clear_logs();
        set_heads();
    endtask

    task automatic wait_drain(input int budget, input bit rnd_alf, output bit ok);
        bit idle;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            sync();
            bus.out_alf = rnd_alf ? ($urandom_range(0, 3) == 0) : 1'b0;
            idle = (obs.size() == exp_q.size());
            for (int i = 0; i < N; i++) if (mq[i].size() > 0 || dq[i].size() > 0) idle = 1'b0;
            ok = idle;
        end
        bus.out_alf = 1'b0;
        repeat (3) sync();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_alf = 1'b0;
        flush_all();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.out_data_wr, bus.out_meta_wr, bus.out_data, bus.out_meta, bus.grant_id,
             bus.zero_len_cnt, bus.src_meta_rd, bus.src_data_rd} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wr=%b/%b gid=%0d zcnt=%0d, want all zero",
                     bus.out_data_wr, bus.out_meta_wr, bus.grant_id, bus.zero_len_cnt);
        end
        sync();
        rst_n = 1'b1;
        m_rr = N - 1;
        m_zc = 0;
        @(negedge clk);
        vectors++;
        if ({bus.out_data_wr, bus.out_meta_wr, bus.grant_id, bus.src_meta_rd} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got wr=%b/%b gid=%0d mrd=%b, want zero",
                     bus.out_data_wr, bus.out_meta_wr, bus.grant_id, bus.src_meta_rd);
        end
    endtask

    task automatic test_single();
        logic [MW-1:0] m;
        bit ok;
        sync();
        clear_logs();
        add_pkt(0, 64, 1'b1, aa);
        run_model();
        m = exp_q[0].v[MW-1:0];
        @(negedge clk);
        vectors++;
        if (bus.src_meta_rd !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_meta_rd: got %b, want 0001", bus.src_meta_rd);
        end
        @(negedge clk);
        vectors++;
        if ({bus.out_meta_wr, bus.grant_id, bus.out_meta, bus.src_data_rd} !== {1'b1, 3'd0, m, 4'b0001}) begin
            miscompares++;
            $display("FAIL single_meta_wr: got wr=%b gid=%0d drd=%b meta=%h, want 1/0/0001/%h",
                     bus.out_meta_wr, bus.grant_id, bus.src_data_rd, bus.out_meta, m);
        end
        @(negedge clk);
        vectors++;
        if ({bus.out_data_wr, bus.out_meta_wr, bus.out_data} !== {2'b10, aa}) begin
            miscompares++;
            $display("FAIL single_data_wr: got wr=%b/%b data=%h, want 1/0 %h",
                     bus.out_data_wr, bus.out_meta_wr, bus.out_data, aa);
        end
        @(negedge clk);
        vectors++;
        if ({bus.out_data_wr, bus.out_meta_wr, bus.src_meta_rd, bus.src_data_rd} !== '0) begin
            miscompares++;
            $display("FAIL single_back_idle: got dwr=%b mwr=%b mrd=%b drd=%b, want 0",
                     bus.out_data_wr, bus.out_meta_wr, bus.src_meta_rd, bus.src_data_rd);
        end
        wait_drain(20, 1'b0, ok);
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL single_events: got %0d, want %0d", obs.size(), exp_q.size());
        end
    endtask

    task automatic test_rr_order();
        bit ok;
        sync();
        clear_logs();
        for (int s = 0; s < N; s++) add_pkt(s, 130, 1'b0, '0);
        add_pkt(0, 130, 1'b0, '0);
        run_model();
        wait_drain(300, 1'b0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_drain: got timeout, want drained");
        end
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rr_events: got %0d, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rr_ev%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
        for (int i = 1; i < meta_cyc.size(); i++) begin
            vectors++;
            if (meta_cyc[i] - meta_cyc[i-1] != 4) begin
                miscompares++;
                $display("FAIL rr_period%0d: got %0d cycles, want 4", i, meta_cyc[i] - meta_cyc[i-1]);
            end
        end
    endtask

    task automatic test_alf();
        bit ok;
        sync();
        clear_logs();
        add_pkt(1, 1500, 1'b0, '0);
        run_model();
        for (int c = 0; c < 100 && obs.size() < 9; c++) sync();
        bus.out_alf = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            vectors++;
            if (bus.src_data_rd !== '0 || (j > 0 && bus.out_data_wr !== 1'b0)) begin
                miscompares++;
                $display("FAIL alf_hold%0d: got drd=%b dwr=%b, want 0/0", j, bus.src_data_rd, bus.out_data_wr);
            end
            sync();
        end
        bus.out_alf = 1'b0;
        wait_drain(200, 1'b0, ok);
        vectors++;
        if (!ok || obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL alf_events: got %0d (drained=%b), want %0d", obs.size(), ok, exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL alf_ev%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        sync();
        clear_logs();
        vectors++;
        if (bus.zero_len_cnt !== 16'(m_zc)) begin
            miscompares++;
            $display("FAIL zlen_before: got %0d, want %0d", bus.zero_len_cnt, m_zc);
        end
        add_pkt(2, 0, 1'b0, '0);
        add_pkt(2, 100, 1'b0, '0);
        run_model();
        wait_drain(100, 1'b0, ok);
        vectors++;
        if (!ok || bus.zero_len_cnt !== 16'(m_zc)) begin
            miscompares++;
            $display("FAIL zlen_after: got %0d (drained=%b), want %0d", bus.zero_len_cnt, ok, m_zc);
        end
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL zlen_events: got %0d, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL zlen_ev%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        sync();
        clear_logs();
        add_pkt(2, 1500, 1'b0, '0);
        run_model();
        for (int c = 0; c < 100 && obs.size() < 11; c++) sync();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_data_wr, bus.out_meta_wr, bus.out_data, bus.out_meta, bus.grant_id,
             bus.zero_len_cnt, bus.src_meta_rd, bus.src_data_rd} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got wr=%b/%b gid=%0d zcnt=%0d drd=%b, want all zero",
                     bus.out_data_wr, bus.out_meta_wr, bus.grant_id, bus.zero_len_cnt, bus.src_data_rd);
        end
        flush_all();
        m_rr = N - 1;
        m_zc = 0;
        repeat (2) sync();
        rst_n = 1'b1;
        sync();
        add_pkt(1, 200, 1'b0, '0);
        add_pkt(0, 64, 1'b0, '0);
        run_model();
        wait_drain(100, 1'b0, ok);
        vectors++;
        if (obs.size() == 0 || obs[0].g !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_first_grant: got %0d (events %0d), want 0",
                     (obs.size() > 0) ? obs[0].g : 3'd7, obs.size());
        end
        vectors++;
        if (!ok || obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midrst_events: got %0d (drained=%b), want %0d", obs.size(), ok, exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midrst_ev%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_prio();
        bit ok;
        sync();
        clear_logs();
        for (int p = 0; p < 3; p++) add_pkt(0, $urandom_range(1, 300), 1'b0, '0);
        for (int p = 0; p < 2; p++) add_pkt(1, $urandom_range(1, 300), 1'b0, '0);
        run_model();
        wait_drain(300, 1'b0, ok);
        vectors++;
        if (!ok || obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL prio_events: got %0d (drained=%b), want %0d", obs.size(), ok, exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL prio_ev%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        for (int r = 0; r < 4; r++) begin
            sync();
            clear_logs();
            for (int s = 0; s < N; s++)
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2047);
                    add_pkt(s, len, 1'b0, '0);
                end
            run_model();
            wait_drain(4000, 1'b1, ok);
            vectors++;
            if (!ok || obs.size() != exp_q.size() || pop_err != 0) begin
                miscompares++;
                $display("FAIL rand%0d_events: got %0d (drained=%b pop_err=%0d), want %0d",
                         r, obs.size(), ok, pop_err, exp_q.size());
            end
            vectors++;
            if (bus.zero_len_cnt !== 16'(m_zc)) begin
                miscompares++;
                $display("FAIL rand%0d_zlen: got %0d, want %0d", r, bus.zero_len_cnt, m_zc);
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (obs[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_ev%0d: got %h, want %h", r, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        aa = {65{8'hAA}};
        test_reset();
        test_single();
        test_rr_order();
        test_alf();
        test_zero_len();
        test_reset_mid();
        test_prio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
